fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port of an async_fifo between NUM_REQ requesters in the write clock domain.
- Grants one requester at a time for a burst, which ends on a last-word marker or after MAX_BURST words.
- Drives the FIFO write enable and write data from registers.
- Stalls on the FIFO's almost-full flag so that the FIFO never overflows.

---
 rtl/fifo_wr_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one async FIFO write port
// between NUM_REQ requesters in the write clock domain. A grant lasts for
// one burst, which ends on a last-word marker, after MAX_BURST words, or when
// the owner drops its request while the FIFO has room. Writes are registered
// (1-cycle latency) and stall while the FIFO reports almost-full.
// Optional feature macro: FIFO_WR_ARB_STALL_CNT_EN adds a saturating stall
// counter output (stall_cnt) and its synchronous clear input (stall_clr).
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic                      fifo_afull,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt,
  input  logic                      stall_clr
`endif
);

  localparam int               IDX_W       = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]   NUM_REQ_L   = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [7:0]       MAX_BURST_L = 8'(MAX_BURST);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // registered state
  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_idx;    // index of current owner (valid in BURST)
  logic [IDX_W-1:0]   r_ptr;    // last served requester
  logic [7:0]         r_count;  // words accepted in this burst
  logic               r_wr_en;
  logic [DATA_W-1:0]  r_data;

  // combinational signals
  logic               w_sel_req;
  logic               w_sel_last;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic [NUM_REQ-1:0] w_win_oh;
  logic               w_accept;
  logic               w_abandon;
  logic [7:0]         w_count_inc;
  state_t             w_state_nx;
  logic [NUM_REQ-1:0] w_grant_nx;
  logic [IDX_W-1:0]   w_idx_nx;
  logic [IDX_W-1:0]   w_ptr_nx;
  logic [7:0]         w_count_nx;
  logic               w_wr_en_nx;
  logic [DATA_W-1:0]  w_data_nx;

  // Mux out the owner's request, last marker and data word.
  always_comb begin
    w_sel_req  = 1'b0;
    w_sel_last = 1'b0;
    w_sel_data = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_req  = (r_idx == IDX_W'(i)) ? req[i]                     : w_sel_req;
      w_sel_last = (r_idx == IDX_W'(i)) ? req_last[i]                : w_sel_last;
      w_sel_data = (r_idx == IDX_W'(i)) ? req_data[i*DATA_W +: DATA_W] : w_sel_data;
    end
  end

  // Round-robin search: first requesting index above the pointer, wrapping.
  always_comb begin : arb_search
    logic [IDX_W:0] sum_v;
    logic [IDX_W:0] cand_v;
    logic           take_v;
    w_found = 1'b0;
    w_win   = r_ptr;
    sum_v   = {(IDX_W+1){1'b0}};
    cand_v  = {(IDX_W+1){1'b0}};
    take_v  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum_v   = {1'b0, r_ptr} + (IDX_W+1)'(k);
      cand_v  = (sum_v >= NUM_REQ_L) ? (sum_v - NUM_REQ_L) : sum_v;
      take_v  = ~w_found & req[cand_v[IDX_W-1:0]];
      w_win   = take_v ? cand_v[IDX_W-1:0] : w_win;
      w_found = w_found | take_v;
    end
  end

  assign w_win_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_count_inc = r_count + 8'd1;
  // Accept only for the owner while the FIFO has room.
  assign w_accept    = (r_state == ST_BURST) & w_sel_req & ~fifo_afull;
  // An owner dropping its request ends the burst, but only outside a stall.
  assign w_abandon   = (r_state == ST_BURST) & ~w_sel_req & ~fifo_afull;

  // Next-state and next-output logic for the IDLE/BURST controller.
  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_idx_nx   = r_idx;
    w_ptr_nx   = r_ptr;
    w_count_nx = r_count;
    w_wr_en_nx = 1'b0;
    w_data_nx  = r_data;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nx = ST_BURST;
          w_grant_nx = w_win_oh;
          w_idx_nx   = w_win;
          w_count_nx = 8'd0;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (w_accept) begin
          w_wr_en_nx = 1'b1;
          w_data_nx  = w_sel_data;
          w_count_nx = w_count_inc;
          if (w_sel_last || (w_count_inc == MAX_BURST_L)) begin
            w_state_nx = ST_IDLE;
            w_grant_nx = {NUM_REQ{1'b0}};
            w_ptr_nx   = r_idx;
          end else begin
            w_state_nx = ST_BURST;
          end
        end else if (w_abandon) begin
          w_state_nx = ST_IDLE;
          w_grant_nx = {NUM_REQ{1'b0}};
          w_ptr_nx   = r_idx;
        end else begin
          // stall: grant, count and pointer all hold
          w_state_nx = ST_BURST;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_grant_nx = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // State and output registers; pointer resets so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= {NUM_REQ{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
      r_ptr   <= LAST_IDX;
      r_count <= 8'd0;
      r_wr_en <= 1'b0;
      r_data  <= {DATA_W{1'b0}};
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_idx   <= w_idx_nx;
      r_ptr   <= w_ptr_nx;
      r_count <= w_count_nx;
      r_wr_en <= w_wr_en_nx;
      r_data  <= w_data_nx;
    end
  end

  assign req_ack    = r_grant & req & {NUM_REQ{~fifo_afull}};
  assign grant      = r_grant;
  assign fifo_wr_en = r_wr_en;
  assign fifo_data  = r_data;
  assign busy       = (r_state == ST_BURST);

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of stalled BURST cycles; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (stall_clr) begin
      r_stall_cnt <= 16'd0;
    end else if ((r_state == ST_BURST) && fifo_afull && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by
// randomized packet traffic, checked against a transaction-level model.
// Expected FIFO words go into a scoreboard queue; a monitor pops them when
// the DUT writes.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req, req_last, req_ack, grant;
  logic [NR*DW-1:0] req_data;
  logic           fifo_afull, fifo_wr_en, busy;
  logic [DW-1:0]  fifo_data;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0]    stall_cnt;
  logic           stall_clr;
  int             m_stall;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: current owner (-1 = none), last served, words in burst
  int            m_owner, m_ptr, m_cnt;
  logic          m_wr;
  logic [NR-1:0] m_ack;
  logic [DW-1:0] exp_q[$];

  // random packet sources
  int plen[NR];
  bit active[NR];

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .fifo_afull(fifo_afull), .fifo_wr_en(fifo_wr_en),
    .fifo_data(fifo_data), .grant(grant), .busy(busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt), .stall_clr(stall_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = NR - 1; m_cnt = 0; m_wr = 1'b0; m_ack = '0;
    exp_q.delete();
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    m_stall = 0;
`endif
  endtask

  // One clock of arbitration rules, evaluated on the inputs presented now.
  task automatic model_step();
    int o;
    bit found;
    m_ack = '0;
    m_wr  = 1'b0;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    if (stall_clr) m_stall = 0;
    else if (m_owner >= 0 && fifo_afull && m_stall < 65535) m_stall++;
`endif
    if (m_owner >= 0) begin
      o = m_owner;
      if (!fifo_afull && req[o]) begin
        m_ack[o] = 1'b1;
        m_wr = 1'b1;
        exp_q.push_back(req_data[o*DW +: DW]);
        m_cnt++;
        if (req_last[o] || m_cnt == MB) begin m_ptr = o; m_owner = -1; end
      end else if (!fifo_afull) begin
        m_ptr = o; m_owner = -1;
      end
    end else begin
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        o = (m_ptr + k) % NR;
        if (!found && req[o]) begin found = 1; m_owner = o; m_cnt = 0; end
      end
    end
  endtask

  // Inputs already driven at posedge+1; check ack, advance, check registers.
  task automatic cycle();
    #1;
    model_step();
    check("req_ack", req_ack, m_ack);
    @(posedge clk); #1;
    check("grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("busy", busy, (m_owner >= 0) ? 32'd1 : 32'd0);
    check("fifo_wr_en", fifo_wr_en, m_wr);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  // Scoreboard monitor: every DUT write must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (fifo_wr_en === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else check("fifo_data", fifo_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int afull_run;
    logic [7:0] words[3];
    int idx, sent, stall_left;
    rst = 1'b1; req = '0; req_last = '0; req_data = '0; fifo_afull = 1'b0;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    model_reset();
    #2;
    check("rst_grant", grant, 4'b0000);
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_data", fifo_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // 1: two requesters without last markers -> MAX_BURST bursts alternate
    req = 4'b0101;
    for (int c = 0; c < 24; c++) begin rand_data(); cycle(); end

    // 2: everyone sends single-word packets -> grant rotates each burst
    req = 4'b1111; req_last = 4'b1111;
    for (int c = 0; c < 12; c++) begin rand_data(); cycle(); end
    req = '0; req_last = '0;
    for (int c = 0; c < 3; c++) cycle();

    // 3: requester 2 sends a 3-word packet 0x11, 0x22, 0x33
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; idx = 0;
    for (int c = 0; c < 12; c++) begin
      rand_data();
      req = (idx < 3) ? 4'b0100 : 4'b0000;
      req_last = (idx == 2) ? 4'b0100 : 4'b0000;
      if (idx < 3) req_data[2*DW +: DW] = words[idx];
      cycle();
      if (m_ack[2]) idx++;
    end
    check("pkt3_words_sent", idx, 3);

    // 4: 8-word burst with afull for 5 cycles after the 3rd word
    sent = 0; stall_left = 5; req_last = '0;
    for (int c = 0; c < 30; c++) begin
      rand_data();
      req = (sent < 8) ? 4'b0010 : 4'b0000;
      if (sent == 3 && stall_left > 0) begin fifo_afull = 1'b1; stall_left--; end
      else fifo_afull = 1'b0;
      cycle();
      if (m_ack[1]) sent++;
    end
    check("afull_burst_words", sent, 8);
    fifo_afull = 1'b0;

    // 5: reset mid-burst between edges, then requester 0 beats requester 3
    req = 4'b0001;
    for (int c = 0; c < 3; c++) begin rand_data(); cycle(); end
    rand_data();
    #1; model_step();
    #1 rst = 1'b1;
    #1;
    check("midrst_grant", grant, 4'b0000);
    check("midrst_wr_en", fifo_wr_en, 1'b0);
    check("midrst_busy", busy, 1'b0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    req = 4'b1001;
    rand_data(); cycle();
    check("post_reset_winner", grant, 4'b0001);
    for (int c = 0; c < 4; c++) begin rand_data(); cycle(); end
    req = '0;
    for (int c = 0; c < 3; c++) cycle();

    // 6: randomized packet traffic with bursty almost-full
    for (int i = 0; i < NR; i++) begin plen[i] = 0; active[i] = 0; end
    afull_run = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (active[i] && m_ack[i]) begin
          plen[i]--;
          if (plen[i] == 0) active[i] = 0;
        end else if (active[i] && $urandom_range(0, 31) == 0) begin
          active[i] = 0;
        end
        if (!active[i] && $urandom_range(0, 3) == 0) begin
          active[i] = 1; plen[i] = $urandom_range(1, 12);
        end
        req[i] = active[i];
        req_last[i] = active[i] && (plen[i] == 1);
      end
      rand_data();
      if (afull_run > 0) begin fifo_afull = 1'b1; afull_run--; end
      else if ($urandom_range(0, 7) == 0) begin fifo_afull = 1'b1; afull_run = $urandom_range(0, 6); end
      else fifo_afull = 1'b0;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      stall_clr = ($urandom_range(0, 63) == 0);
`endif
      cycle();
    end
    req = '0; req_last = '0; fifo_afull = 1'b0;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    for (int c = 0; c < 3; c++) cycle();

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    // 7: long stall saturates the counter; a clear pulse zeroes it
    stall_clr = 1'b1; cycle(); stall_clr = 1'b0;
    req = 4'b0001; cycle();
    fifo_afull = 1'b1;
    for (int c = 0; c < 70000; c++) cycle();
    check("stall_cnt_sat", stall_cnt, 16'hFFFF);
    stall_clr = 1'b1; cycle(); stall_clr = 1'b0;
    check("stall_cnt_clr", stall_cnt, 16'h0000);
    fifo_afull = 1'b0; req = '0;
    for (int c = 0; c < 3; c++) cycle();
`endif

    @(negedge clk); @(negedge clk);
    check("queue_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
